// File: rtl/piece_cursor_if.sv
// piece_cursor_if: keyboard/board inputs and cursor/drop outputs of piece_cursor.
//   keycode    : current HID keycode (0x04 left, 0x07 right, 0x2C drop)
//   land_row   : lowest empty row of the selected column (NUM_ROWS = full)
//   PieceX/Y   : pixel position of the active piece
//   cur_col    : selected column
//   busy       : piece is falling or landing
//   drop_valid : one-cycle landing pulse, drop_row holds the landed row
// master modport drives keycode/land_row; slave modport is the cursor side.
interface piece_cursor_if #(
  parameter int unsigned NUM_COLS = 7,
  parameter int unsigned NUM_ROWS = 6
);
  localparam int unsigned CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned RW = $clog2(NUM_ROWS + 1);

  logic [7:0]    keycode;
  logic [RW-1:0] land_row;
  logic [9:0]    PieceX;
  logic [9:0]    PieceY;
  logic [CW-1:0] cur_col;
  logic          busy;
  logic          drop_valid;
  logic [RW-1:0] drop_row;

  modport master (
    output keycode, land_row,
    input  PieceX, PieceY, cur_col, busy, drop_valid, drop_row
  );

  modport slave (
    input  keycode, land_row,
    output PieceX, PieceY, cur_col, busy, drop_valid, drop_row
  );
endinterface

// File: rtl/piece_cursor.sv
// piece_cursor: column selector and falling-piece animator for a drop-piece board.
// Ports:
//   frame_clk : sole clock, one tick per video frame
//   Reset     : asynchronous active-low reset
//   bus       : piece_cursor_if.slave (keycode/land_row in; PieceX/PieceY,
//               cur_col, busy, drop_valid, drop_row out)
// Keys act only on the cycle the keycode changes. In HOVER left/right move the
// column and drop starts a fall toward land_row; keys are ignored while busy.
// Optional feature: define PIECE_CURSOR_WRAP_EN to wrap the column at both
// ends instead of saturating.
module piece_cursor #(
  parameter int unsigned NUM_COLS  = 7,
  parameter int unsigned NUM_ROWS  = 6,
  parameter int unsigned ORIGIN_X  = 300,
  parameter int unsigned ORIGIN_Y  = 75,
  parameter int unsigned CELL_W    = 40,
  parameter int unsigned CELL_H    = 40,
  parameter int unsigned FALL_STEP = 8
) (
  input logic           frame_clk,
  input logic           Reset,
  piece_cursor_if.slave bus
);
  localparam int unsigned CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned RW = $clog2(NUM_ROWS + 1);

  localparam logic [7:0]    KEY_LEFT  = 8'h04;
  localparam logic [7:0]    KEY_RIGHT = 8'h07;
  localparam logic [7:0]    KEY_DROP  = 8'h2C;
  localparam logic [CW-1:0] COL_MAX   = CW'(NUM_COLS - 1);
  localparam logic [CW-1:0] COL_RST   = CW'(NUM_COLS / 2);
  localparam logic [9:0]    HOVER_Y   = 10'(ORIGIN_Y);
  localparam logic [9:0]    RST_X     = 10'(ORIGIN_X + CELL_W * (NUM_COLS / 2));

  typedef enum logic [1:0] {HOVER, FALL, LAND} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    prev_key_q;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] drop_row_q, drop_row_d;
  logic [9:0]    py_q, py_d;
  logic [9:0]    px_q, px_d;
  logic          busy_q, busy_d;
  logic          dv_q, dv_d;

  logic          key_edge;
  logic [10:0]   step_y;
  logic [10:0]   target_y;

  // State and output registers; reset aborts any fall without a landing pulse.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= HOVER;
      col_q      <= COL_RST;
      prev_key_q <= 8'h00;
      row_q      <= '0;
      drop_row_q <= '0;
      py_q       <= HOVER_Y;
      px_q       <= RST_X;
      busy_q     <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      prev_key_q <= bus.keycode;
      row_q      <= row_d;
      drop_row_q <= drop_row_d;
      py_q       <= py_d;
      px_q       <= px_d;
      busy_q     <= busy_d;
      dv_q       <= dv_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    drop_row_d = drop_row_q;
    py_d       = py_q;
    key_edge   = (bus.keycode != prev_key_q);
    step_y     = 11'(py_q) + 11'(FALL_STEP);
    // Landed piece sits one cell below the hover line per row index.
    target_y   = 11'(ORIGIN_Y) + 11'(CELL_H) * (11'(row_q) + 11'd1);

    case (state_q)
      HOVER: begin
        py_d = HOVER_Y;
        if (key_edge) begin
          case (bus.keycode)
            KEY_LEFT: begin
              if (col_q == '0) begin
`ifdef PIECE_CURSOR_WRAP_EN
                col_d = COL_MAX;
`else
                col_d = '0;
`endif
              end else begin
                col_d = col_q - CW'(1);
              end
            end
            KEY_RIGHT: begin
              if (col_q == COL_MAX) begin
`ifdef PIECE_CURSOR_WRAP_EN
                col_d = '0;
`else
                col_d = COL_MAX;
`endif
              end else begin
                col_d = col_q + CW'(1);
              end
            end
            KEY_DROP: begin
              // A full column reports NUM_ROWS and cannot accept a piece.
              if (bus.land_row < RW'(NUM_ROWS)) begin
                row_d   = bus.land_row;
                state_d = FALL;
              end
            end
            default: ;
          endcase
        end
      end
      FALL: begin
        // Final step snaps to the exact landing Y rather than overshooting.
        if (step_y >= target_y) begin
          py_d       = 10'(target_y);
          drop_row_d = row_q;
          state_d    = LAND;
        end else begin
          py_d = 10'(step_y);
        end
      end
      LAND: begin
        py_d    = HOVER_Y;
        state_d = HOVER;
      end
      default: begin
        py_d    = HOVER_Y;
        state_d = HOVER;
      end
    endcase

    px_d   = 10'(ORIGIN_X) + 10'(CELL_W) * 10'(col_d);
    busy_d = (state_d != HOVER);
    dv_d   = (state_d == LAND);
  end

  assign bus.PieceX     = px_q;
  assign bus.PieceY     = py_q;
  assign bus.cur_col    = col_q;
  assign bus.busy       = busy_q;
  assign bus.drop_valid = dv_q;
  assign bus.drop_row   = drop_row_q;
endmodule

// File: tb/tb_piece_cursor.sv
// tb_piece_cursor: directed stimulus for piece_cursor with a per-cycle
// reference model and hand-computed literal checkpoints.
module tb_piece_cursor;
  localparam int NC = 7;
  localparam int NR = 6;
  localparam int OX = 300;
  localparam int OY = 75;
  localparam int CWP = 40;
  localparam int CHP = 40;
  localparam int FS = 8;
`ifdef PIECE_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic frame_clk = 1'b0;
  logic Reset = 1'b0;

  piece_cursor_if #(.NUM_COLS(NC), .NUM_ROWS(NR)) bus ();

  piece_cursor #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .CELL_W(CWP), .CELL_H(CHP), .FALL_STEP(FS)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 frame_clk = ~frame_clk;

  int n_tests = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  // Model: m_k = 0 hovering, 1..m_n falling frames, m_n+1 landing frame.
  int m_col = NC / 2;
  int m_prev = 0;
  int m_k = 0;
  int m_n = 0;
  int m_row = 0;
  int m_drop_row = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_col = NC / 2;
    m_prev = 0;
    m_k = 0;
    m_n = 0;
    m_drop_row = 0;
  endtask

  task automatic model_step();
    int key;
    bit key_ev;
    key = int'(bus.keycode);
    key_ev = (key != m_prev);
    m_prev = key;
    if (m_k == 0) begin
      if (key_ev) begin
        if (key == 'h04) m_col = (m_col == 0) ? (WRAP ? NC - 1 : 0) : m_col - 1;
        else if (key == 'h07) m_col = (m_col == NC - 1) ? (WRAP ? 0 : NC - 1) : m_col + 1;
        else if (key == 'h2C && int'(bus.land_row) < NR) begin
          m_row = int'(bus.land_row);
          m_n = (CHP * (m_row + 1) + FS - 1) / FS;
          m_k = 1;
        end
      end
    end else if (m_k <= m_n) begin
      m_k++;
      if (m_k == m_n + 1) m_drop_row = m_row;
    end else begin
      m_k = 0;
    end
  endtask

  function automatic int exp_y();
    if (m_k == 0) return OY;
    if (m_k <= m_n) return OY + FS * (m_k - 1);
    return OY + CHP * (m_row + 1);
  endfunction

  // Per-cycle compare against the model.
  always @(posedge frame_clk or negedge Reset) begin
    if (!Reset) model_reset();
    else model_step();
    #1;
    if (armed) begin
      chk("m_x", int'(bus.PieceX), OX + CWP * m_col);
      chk("m_y", int'(bus.PieceY), exp_y());
      chk("m_col", int'(bus.cur_col), m_col);
      chk("m_busy", int'(bus.busy), int'(m_k != 0));
      chk("m_dv", int'(bus.drop_valid), int'(m_k != 0 && m_k == m_n + 1));
      chk("m_drow", int'(bus.drop_row), m_drop_row);
    end
  end

  // One-frame key press followed by one frame of release.
  task automatic tap(input logic [7:0] k);
    @(negedge frame_clk);
    bus.keycode = k;
    @(negedge frame_clk);
    bus.keycode = 8'h00;
  endtask

  int fall_cnt;
  int seen;
  int dv_cnt;
  int busy_cnt;

  initial begin
    bus.keycode = 8'h00;
    bus.land_row = '0;
    Reset = 1'b0;
    repeat (2) @(negedge frame_clk);
    Reset = 1'b1;
    armed = 1'b1;
    chk("rst_col", int'(bus.cur_col), 3);
    chk("rst_x", int'(bus.PieceX), 420);
    chk("rst_y", int'(bus.PieceY), 75);
    chk("rst_busy", int'(bus.busy), 0);

    // Held right key moves exactly once.
    @(negedge frame_clk);
    bus.keycode = 8'h07;
    repeat (10) @(negedge frame_clk);
    bus.keycode = 8'h00;
    repeat (2) @(negedge frame_clk);
    chk("hold_col", int'(bus.cur_col), 4);
    chk("hold_x", int'(bus.PieceX), 460);

    tap(8'h1A);
    @(negedge frame_clk);
    chk("unk_col", int'(bus.cur_col), 4);

    // Drop into row 5; land_row changes and a left key mid-fall must not matter.
    @(negedge frame_clk);
    bus.land_row = 3'd5;
    bus.keycode = 8'h2C;
    @(negedge frame_clk);
    bus.keycode = 8'h00;
    bus.land_row = 3'd2;
    fall_cnt = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.drop_valid) begin
        seen = 1;
        break;
      end
      if (bus.busy) fall_cnt++;
      if (i == 5) bus.keycode = 8'h04;
      if (i == 6) bus.keycode = 8'h00;
      @(negedge frame_clk);
    end
    chk("land_seen", seen, 1);
    chk("fall_cycles", fall_cnt, 30);
    chk("land_y", int'(bus.PieceY), 315);
    chk("land_row", int'(bus.drop_row), 5);
    @(negedge frame_clk);
    chk("post_y", int'(bus.PieceY), 75);
    chk("post_dv", int'(bus.drop_valid), 0);
    chk("post_col", int'(bus.cur_col), 4);

    // Full column: drop ignored.
    bus.land_row = 3'd6;
    bus.keycode = 8'h2C;
    dv_cnt = 0;
    busy_cnt = 0;
    @(negedge frame_clk);
    bus.keycode = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.drop_valid) dv_cnt++;
      @(negedge frame_clk);
    end
    chk("full_busy", busy_cnt, 0);
    chk("full_dv", dv_cnt, 0);

    // Column edges.
    tap(8'h07);
    tap(8'h07);
    chk("col6", int'(bus.cur_col), 6);
    tap(8'h07);
    chk("right_edge", int'(bus.cur_col), WRAP ? 0 : 6);
    for (int i = 0; i < 7; i++) tap(8'h04);
    chk("left_walk", int'(bus.cur_col), 0);
    tap(8'h04);
    chk("left_edge", int'(bus.cur_col), WRAP ? 6 : 0);
    chk("left_edge_x", int'(bus.PieceX), WRAP ? 540 : 300);

    // Reset during the 10th fall frame aborts the drop.
    @(negedge frame_clk);
    bus.land_row = 3'd5;
    bus.keycode = 8'h2C;
    @(negedge frame_clk);
    bus.keycode = 8'h00;
    repeat (9) @(negedge frame_clk);
    chk("fall10_busy", int'(bus.busy), 1);
    chk("fall10_y", int'(bus.PieceY), 75 + 8 * 9);
    #1;
    Reset = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_col", int'(bus.cur_col), 3);
    chk("abort_y", int'(bus.PieceY), 75);
    chk("abort_x", int'(bus.PieceX), 420);
    chk("abort_drow", int'(bus.drop_row), 0);
    @(negedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b1;
    dv_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge frame_clk);
      if (bus.drop_valid) dv_cnt++;
      if (bus.busy) busy_cnt++;
    end
    chk("abort_no_dv", dv_cnt, 0);
    chk("abort_no_busy", busy_cnt, 0);
    chk("abort_col_hold", int'(bus.cur_col), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/piece_cursor.md
PIECE_CURSOR -- requirements
Module: piece_cursor

Interface
REQ-001 Parameter NUM_COLS, default 7, number of board columns.
REQ-002 Parameter NUM_ROWS, default 6, number of board rows (row 0 = top).
REQ-003 Parameter ORIGIN_X, default 300, pixel X of column 0 piece.
REQ-004 Parameter ORIGIN_Y, default 75, pixel Y of hover position.
REQ-005 Parameter CELL_W / CELL_H, default 40 / 40, pixel pitch per column / row.
REQ-006 Parameter FALL_STEP, default 8, pixels descended per frame_clk during fall.
REQ-007 frame_clk  input  1  sole clock; one tick per video frame.
REQ-008 Reset  input  1  asynchronous, active-low reset.
REQ-009 keycode  input  8  current HID keycode; 0x04 = left, 0x07 = right, 0x2C = drop, 0x00 = none.
REQ-010 land_row  input  RW = $clog2(NUM_ROWS+1)  lowest empty row of cur_col from board; value NUM_ROWS = column full.
REQ-011 PieceX, PieceY  output  10 each  pixel position of the active piece.
REQ-012 cur_col  output  $clog2(NUM_COLS)  selected column.
REQ-013 busy  output  1  high in FALL and LAND states.
REQ-014 drop_valid  output  1  one-cycle pulse on landing; drop_row output (RW bits) holds landed row, valid with pulse.

Function
REQ-015 States: HOVER, FALL, LAND; all registered on frame_clk.
REQ-016 Key edge detect: a command acts only in the cycle keycode differs from its registered previous value; held keys act once.
REQ-017 HOVER, left edge: cur_col decrements; at 0 behaviour per REQ-026.
REQ-018 HOVER, right edge: cur_col increments; at NUM_COLS-1 behaviour per REQ-026.
REQ-019 HOVER, drop edge with land_row < NUM_ROWS: latch land_row into target row, go FALL next cycle; land_row = NUM_ROWS: ignored, stay HOVER.
REQ-020 PieceX = ORIGIN_X + CELL_W*cur_col, combinationally from cur_col in all states.
REQ-021 HOVER: PieceY = ORIGIN_Y; FALL: PieceY += FALL_STEP per cycle; if PieceY + FALL_STEP >= target Y (ORIGIN_Y + CELL_H*(row+1)), PieceY loads target Y exactly and state goes LAND.
REQ-022 LAND lasts exactly one cycle: drop_valid = 1, drop_row = latched row; next cycle HOVER, PieceY = ORIGIN_Y, cur_col unchanged.
REQ-023 All keycodes ignored in FALL and LAND; previous-key register still updates every cycle.
REQ-024 land_row sampled only in the drop-edge cycle; later changes do not affect an in-progress fall.
REQ-025 Unrecognised keycodes have no effect.

Configuration
REQ-026 Macro PIECE_CURSOR_WRAP_EN defined: left at col 0 -> NUM_COLS-1, right at NUM_COLS-1 -> 0; undefined: cur_col saturates at both ends.

Reset
REQ-027 Reset low (any time, including mid-fall): state HOVER, cur_col = NUM_COLS/2 (3), PieceY = ORIGIN_Y, drop_valid = 0, drop_row = 0, busy = 0, previous-key register = 0x00.
REQ-028 No drop_valid pulse is produced for a fall aborted by reset.

Verification
REQ-029 Reset release, defaults -> cur_col = 3, PieceX = 420, PieceY = 75, busy = 0.
REQ-030 keycode 0x07 held 10 frames then 0x00 -> cur_col = 4, PieceX = 460 (single move).
REQ-031 cur_col = 4, land_row = 5, keycode 0x2C -> busy next cycle, PieceY 75, 83, ... reaches 315 after 30 FALL cycles, then drop_valid pulse one cycle with drop_row = 5, then PieceY = 75.
REQ-032 land_row = 6, keycode 0x2C -> no state change, busy = 0, no drop_valid.
REQ-033 cur_col = 6, keycode 0x07 -> cur_col = 0 with PIECE_CURSOR_WRAP_EN, cur_col = 6 without.
REQ-034 Reset asserted at 10th FALL cycle -> immediately HOVER, cur_col = 3, PieceY = 75, no drop_valid after release.
